// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM + MMIO (console TX FIFO, cycle counter, scratch); reads are 0-latency.
// Writes land on the next edge; console bytes leave over valid/ready and a full FIFO drops pushes (sticky ovf).
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   scratch_q, scratch_d;

  logic [AW-1:0] ram_idx;
  logic [1:0]    mmio_off;
  logic          is_ram, is_mmio, wr_en, rd_en;
  logic          fifo_full, fifo_empty, pop, push_req, push, ovf_set;
  logic [31:0]   status;
  logic          unused_addr_bits;

  assign ram_idx          = data_addr_i[AW+1:2];
  assign mmio_off         = data_addr_i[3:2];
  assign is_ram           = data_addr_i < MMIO_BASE;
  // Base is 16-byte aligned, so matching the upper bits selects exactly the window.
  assign is_mmio          = data_addr_i[31:4] == MMIO_BASE[31:4];
  assign wr_en            = data_ce_i & data_we_i;
  assign rd_en            = data_ce_i & ~data_we_i;
  assign unused_addr_bits = ^data_addr_i[1:0];

  assign fifo_full  = count_q == FULL_CNT;
  assign fifo_empty = count_q == '0;
  assign pop        = ~fifo_empty & con_ready_i;
  assign push_req   = wr_en & is_mmio & (mmio_off == 2'd0);
  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign push       = push_req & (~fifo_full | pop);
  assign ovf_set    = push_req & fifo_full & ~pop;
  assign status     = {16'h0, 8'(count_q), 5'h0, ovf_q, fifo_empty, fifo_full};

  assign con_valid_o = ~fifo_empty;
  assign con_data_o  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    cycle_d   = cycle_q + 32'd1;
    scratch_d = scratch_q;
    if (push) begin
      fifo_d[wr_ptr_q] = data_wdata_i[7:0];
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
    if (wr_en && is_mmio) begin
      case (mmio_off)
        2'd1:    if (data_wdata_i[2]) ovf_d = 1'b0;
        2'd2:    cycle_d   = data_wdata_i;
        2'd3:    scratch_d = data_wdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    data_rdata_o = 32'h0;
    if (rd_en) begin
      if (is_ram) begin
        data_rdata_o = ram_q[ram_idx];
      end else if (is_mmio) begin
        case (mmio_off)
          2'd1:    data_rdata_o = status;
          2'd2:    data_rdata_o = cycle_q;
          2'd3:    data_rdata_o = scratch_q;
          default: data_rdata_o = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      cycle_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
    end
  end

  // Storage arrays carry no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (rst && wr_en && is_ram) begin
      ram_q[ram_idx] <= data_wdata_i;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed plan steps plus a randomized phase checked against a queue-based model.
module tb_dmem_responder;
  localparam int          DW   = 1024;
  localparam int          FD   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .data_ce_i(ce), .data_we_i(we), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rdata),
    .con_valid_o(con_valid), .con_data_o(con_data), .con_ready_i(con_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram_m [int];
  logic [7:0]  q_m [$];
  logic        ovf_m = 1'b0;
  logic [31:0] cycle_m = 32'h0;
  logic [31:0] scratch_m = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ridx(input logic [31:0] a);
    return int'((a >> 2) % DW);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < BASE) begin
      if (ram_m.exists(ridx(a))) return ram_m[ridx(a)];
      return 32'hx;
    end
    if (a >= BASE && a < BASE + 32'd16) begin
      case (a[3:2])
        2'd1:    return {16'h0, 8'(q_m.size()), 5'h0, ovf_m, q_m.size() == 0, q_m.size() == FD};
        2'd2:    return cycle_m;
        2'd3:    return scratch_m;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  // Advance the model by one edge using the inputs currently driven, then step the DUT.
  task automatic tick();
    bit full, pop;
    if (!rst) begin
      q_m.delete();
      ovf_m = 1'b0;
      cycle_m = 32'h0;
      scratch_m = 32'h0;
    end else begin
      full = (q_m.size() == FD);
      pop  = (q_m.size() > 0) && con_ready;
      if (pop) void'(q_m.pop_front());
      cycle_m = cycle_m + 32'd1;
      if (ce && we) begin
        if (addr < BASE) ram_m[ridx(addr)] = wdata;
        else if (addr < BASE + 32'd16) begin
          case (addr[3:2])
            2'd0: if (full && !pop) ovf_m = 1'b1; else q_m.push_back(wdata[7:0]);
            2'd1: if (wdata[2]) ovf_m = 1'b0;
            2'd2: cycle_m = wdata;
            default: scratch_m = wdata;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rdm(input string tag, input logic [31:0] a);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, rdata, model_read(a));
    ce = 1'b0;
  endtask

  task automatic rdk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = a;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_model"}, rdata, model_read(a));
    ce = 1'b0;
  endtask

  task automatic con_chk(input string tag);
    chk({tag, "_valid"}, {31'h0, con_valid}, {31'h0, q_m.size() > 0});
    chk({tag, "_data"}, {24'h0, con_data}, (q_m.size() > 0) ? {24'h0, q_m[0]} : 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old;
    int op;

    tick();
    tick();
    con_chk("rst");
    rdk("rst_status", BASE + 32'h4, 32'h2);
    rdk("rst_scratch", BASE + 32'hC, 32'h0);
    rdk("rst_cycle", BASE + 32'h8, 32'h0);

    rst = 1'b1;
    repeat (5) tick();
    rdk("cycle5", BASE + 32'h8, 32'd5);
    wr(BASE + 32'h8, 32'hFFFF_FFFE);
    rdk("cyc_load", BASE + 32'h8, 32'hFFFF_FFFE);
    tick();
    rdk("cyc_inc", BASE + 32'h8, 32'hFFFF_FFFF);
    tick();
    rdk("cyc_wrap", BASE + 32'h8, 32'h0);

    wr(32'h10, 32'hDEAD_BEEF);
    rdk("ram_rd", 32'h10, 32'hDEAD_BEEF);
    rdk("ram_lowbits", 32'h13, 32'hDEAD_BEEF);
    rdk("ram_wrap", 32'h1010, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom);
    rdm("ram_pool0", 32'h0);
    rdm("ram_pool15", 32'h3C);

    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(BASE, 32'h41 + 32'(i));
    rdk("ovf_status", BASE + 32'h4, 32'h805);
    con_chk("ovf_head");
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", {24'h0, con_data}, 32'h41 + 32'(i));
      con_chk("drain");
      tick();
    end
    chk("drain_done", {31'h0, con_valid}, 32'h0);
    rdk("drain_status", BASE + 32'h4, 32'h6);
    wr(BASE + 32'h4, 32'h4);
    rdk("ovf_clr", BASE + 32'h4, 32'h2);

    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(BASE, 32'h30 + 32'(i));
    rdk("full_status", BASE + 32'h4, 32'h801);
    con_ready = 1'b1;
    wr(BASE, 32'h5A);
    con_ready = 1'b0;
    rdk("pushpop_status", BASE + 32'h4, 32'h801);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pp_byte", {24'h0, con_data}, (i < 7) ? 32'h31 + 32'(i) : 32'h5A);
      con_chk("pp_drain");
      tick();
    end
    con_ready = 1'b0;

    wr(BASE + 32'hC, 32'hCAFE_F00D);
    rdk("scratch", BASE + 32'hC, 32'hCAFE_F00D);

    wr(BASE, 32'h77);
    rdk("oow_rd", BASE + 32'h20, 32'h0);
    wr(BASE + 32'h20, 32'h1234);
    rdk("oow_rd2", BASE + 32'h20, 32'h0);
    rdk("oow_status", BASE + 32'h4, 32'h100);
    rdk("oow_scratch", BASE + 32'hC, 32'hCAFE_F00D);
    con_chk("oow_con");

    for (int it = 0; it < 400; it++) begin
      con_ready = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)) * DW * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      con_chk("rnd_con");
      case (op)
        0: wr(a, d);
        1: begin rdm("rnd_ram", a); tick(); end
        2: wr(BASE, d);
        3: begin rdm("rnd_status", BASE + 32'h4); tick(); end
        4: wr(BASE + 32'h4, d);
        5: begin rdm("rnd_cycle", BASE + 32'h8); tick(); end
        6: if (d[0]) wr(BASE + 32'hC, d); else begin rdm("rnd_scratch", BASE + 32'hC); tick(); end
        default: begin
          a = BASE + 32'h10 + 32'($urandom_range(0, 1 << 20)) * 4;
          if (d[1]) wr(a, d); else begin rdm("rnd_oow", a); tick(); end
        end
      endcase
    end

    con_ready = 1'b1;
    for (int k = 0; k < 20 && q_m.size() > 0; k++) tick();
    con_ready = 1'b0;
    wr(BASE + 32'h4, 32'h4);
    wr(BASE + 32'hC, 32'h5555_AAAA);
    for (int i = 0; i < 9; i++) wr(BASE, 32'h60 + 32'(i));
    rdk("pre_rst_status", BASE + 32'h4, 32'h805);
    old = ram_m[2];
    rst = 1'b0;
    ce = 1'b1; we = 1'b1; addr = 32'h8; wdata = ~old;
    tick();
    ce = 1'b0; we = 1'b0;
    con_chk("mid_rst");
    rdk("mid_rst_status", BASE + 32'h4, 32'h2);
    rdk("mid_rst_scratch", BASE + 32'hC, 32'h0);
    rdk("mid_rst_ram", 32'h8, old);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
